// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the async-FIFO write-port arbiter.
// Defines the arbiter state encoding and the default index and counter widths.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int maxburst);
    return $clog2(maxburst) + 1;
  endfunction

  localparam int NREQ_DEF     = 4;
  localparam int MAXBURST_DEF = 4;
  localparam int REQ_IDX_W    = idx_w(NREQ_DEF);
  localparam int CNT_W        = cnt_w(MAXBURST_DEF);

endpackage

// File: rtl/fifo_wr_rr_pick.sv
// Combinational rotating-priority picker: the first set request after rr_ptr wins.
// Outputs the winner both as a one-hot vector and as an index, plus an any-request flag.
module fifo_wr_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   winner_idx,
  output logic            any
);

  logic [IW-1:0] cand;

  // The search starts one past rr_ptr, so the most recent owner has the lowest priority.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    any        = 1'b0;
    cand       = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(rr_ptr) + i) % NREQ);
      if (!any && req[cand]) begin
        any          = 1'b1;
        winner[cand] = 1'b1;
        winner_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that shares the FIFO write port among NREQ producers.
// Each grant lasts for one packet or for at most MAXBURST words, and no write is made while wfull is high.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DSIZE    = 8,
  parameter int NREQ     = NREQ_DEF,
  parameter int MAXBURST = MAXBURST_DEF
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic [DSIZE-1:0]      wdata,
  output logic                  winc,
  output logic [NREQ-1:0]       grant,
  output logic                  busy
);

  localparam int IW = idx_w(NREQ);
  localparam int BW = cnt_w(MAXBURST);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;

  logic [NREQ-1:0]  pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [IW-1:0]    g_idx;
  logic             sel_valid;
  logic             sel_last;
  logic [DSIZE-1:0] sel_data;
  logic             at_cap;

  fifo_wr_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req        (req_valid),
    .rr_ptr     (rr_ptr_q),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .any        (pick_any)
  );

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= IW'(NREQ - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // The one-hot grant steers the mux directly; the index is only needed for rr_ptr on release.
  always_comb begin
    g_idx     = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        g_idx     = IW'(i);
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  always_comb begin
    busy        = (state_q == XFER);
    winc        = busy & sel_valid & ~wfull;
    req_ready   = (busy && !wfull) ? grant_q : '0;
    wdata       = busy ? sel_data : '0;
    grant       = grant_q;
    at_cap      = (burst_cnt_q == BW'(MAXBURST - 1));
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d     = XFER;
          grant_d     = pick_onehot;
          burst_cnt_d = '0;
        end
      end
      XFER: begin
        if (winc) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          // Release goes through IDLE, which always leaves one idle cycle between grants.
          if (sel_last || at_cap) begin
            state_d     = IDLE;
            grant_d     = '0;
            rr_ptr_d    = g_idx;
            burst_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of the async FIFO between NREQ requesters in the write clock domain.
- Round-robin arbitration; each grant is held for one packet or at most MAXBURST words, whichever ends first.
- Drives the FIFO's wdata/winc and obeys wfull, so no requester ever sees the FIFO directly.
- Sits between the producer clients and the FIFO write side; it is the sole driver of winc.

Parameters:
- DSIZE, 8, data word width; matches the FIFO DSIZE.
- NREQ, 4, number of requesters (2..16).
- MAXBURST, 4, maximum words written per grant (1..256).

Ports:
- wclk  input  1  write-domain clock.
- wrst  input  1  reset: synchronous, active-high.
- req_valid  input  NREQ  per-requester word valid.
- req_data  input  NREQ*DSIZE  requester i occupies bits [i*DSIZE +: DSIZE].
- req_last  input  NREQ  marks the final word of a packet.
- req_ready  output  NREQ  word accepted this cycle for that requester.
- wfull  input  1  FIFO full flag (write domain).
- wdata  output  DSIZE  FIFO write data.
- winc  output  1  FIFO write strobe.
- grant  output  NREQ  one-hot current owner; zero when IDLE.
- busy  output  1  high in XFER.

Behaviour:
- Reset (wrst=1 at a wclk edge): state=IDLE, grant=0, rr_ptr=NREQ-1 (requester 0 wins first), burst_cnt=0.
- Reset outputs: winc=0, req_ready=0, busy=0, wdata=0.
- Reset mid-burst aborts the grant. Words already written stay in the FIFO; there is no rollback.
- Internal state: state, grant, rr_ptr and burst_cnt are the only registers.
- IDLE:
  - If any req_valid is high, pick the first requester with req_valid set, searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - Register the winner as grant, clear burst_cnt, and go to XFER.
  - Otherwise remain in IDLE.
- Latency: arbitration takes one cycle. The earliest write is the cycle after req_valid is first sampled high in IDLE.
- XFER (g = granted index):
  - Outputs are combinational from the registered grant:
    - req_ready[g] = !wfull.
    - winc = req_valid[g] & !wfull.
    - wdata = req_data[g].
    - req_ready of all other requesters = 0.
  - A transfer occurs when winc=1 at the clock edge.
  - Each transfer increments burst_cnt (width clog2(MAXBURST)+1).
  - Release condition: a transfer with req_last[g]=1, or a transfer with burst_cnt==MAXBURST-1.
  - On release: state goes to IDLE, grant=0, rr_ptr=g. This forces one idle cycle between grants.
  - req_valid[g] low mid-packet: the grant is held with no transfer. There is no timeout; packet integrity takes priority over fairness.
  - A MAXBURST cut mid-packet is legal. The requester resumes its packet at its next grant; words may be interleaved with other packets.
- wfull:
  - wfull=1 gives winc=0, req_ready=0, and burst_cnt unchanged.
  - There is no write while full, ever.
  - A word offered while full is not consumed; it is written on the first non-full cycle.
- Simultaneous events: req_last and the burst limit in the same transfer cause a single release, same as either alone.
- When not in XFER, wdata is driven to 0.
- Fairness: with all requesters continuously valid, the grant order is 0,1,...,NREQ-1,0,...

Decomposition:
- Shared package fifo_arb_pkg:
  - State enum {IDLE, XFER}.
  - Constants: REQ_IDX_W = clog2(NREQ) and CNT_W = clog2(MAXBURST)+1.
- One sub-module fifo_wr_rr_pick: purely combinational rotating-priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot winner, winner index, any.
- The FSM, burst counter and output muxing live in the top.

Test Plan:
- Reset then a single requester: req_valid[2]=1 with 3 words, last on word 3 -> grant=0100 the cycle after, winc high 3 consecutive cycles, wdata in order, grant=0 after word 3.
- All 4 requesters valid, 1-word packets -> grants in order 0,1,2,3,0 with one idle cycle between each; no requester skipped.
- Burst cap, MAXBURST=4, requester 1 sends an 8-word packet while requester 3 is also valid -> words 1-4 from req1, then req3's packet, then words 5-8 of req1.
- wfull asserted for 5 cycles mid-burst -> winc=0 and req_ready=0 during those cycles, the word is held, burst_cnt unchanged, writing resumes when wfull drops, no word lost or duplicated.
- req_valid[g] drops for 3 cycles mid-packet while others are valid -> grant held, no writes, packet completes afterwards.
- wrst=1 for one cycle during a transfer -> the next cycle shows grant=0, winc=0, busy=0; the following arbitration favours requester 0.
